// File: rtl/kalman_update_if.sv
// Port bundle for kalman_update: start/done handshake, packed input operands
// (predicted state, measurement, gain, predicted covariance) and packed results.
interface kalman_update_if #(
    parameter int DW = 32
);
    logic              start;
    logic [6*DW-1:0]   x_hat_flat;
    logic [4*DW-1:0]   z_flat;
    logic [24*DW-1:0]  K_flat;
    logic [36*DW-1:0]  Phat_flat;
    logic [6*DW-1:0]   x_flat;
    logic [36*DW-1:0]  P_flat;
    logic              busy;
    logic              done;

    modport master (
        output start, x_hat_flat, z_flat, K_flat, Phat_flat,
        input  x_flat, P_flat, busy, done
    );

    modport slave (
        input  start, x_hat_flat, z_flat, K_flat, Phat_flat,
        output x_flat, P_flat, busy, done
    );
endinterface

// File: rtl/kalman_update.sv
// Kalman measurement update (6 states, 4 measurements, Q20.12):
//   x_out = x_hat + K(z - H x_hat),  P_out = P_hat - K H P_hat
// H selects state indices {0,1,4,5}. One time-multiplexed signed MAC.
// Latency from accepting edge to done: 4 + 24 + 144 = 172 clocks.
// Optional macro KALMAN_UPDATE_SAT_EN: saturate y, x_new and P_new to DW bits
// instead of two's-complement wrap.
module kalman_update #(
    parameter int DW   = 32,
    parameter int FRAC = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    kalman_update_if.slave  io
);
    localparam int PW = 2 * DW;   // full product width
    localparam int AW = PW + 2;   // accumulator width
    localparam int RW = AW + 1;   // width of sums before reduction

`ifdef KALMAN_UPDATE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_INNOV, ST_XUPD, ST_PUPD, ST_DONE
    } state_t;

    state_t state, state_next;

    logic [DW-1:0] x_hat_r [6];
    logic [DW-1:0] z_r     [4];
    logic [DW-1:0] k_r     [24];
    logic [DW-1:0] ph_r    [36];
    logic [DW-1:0] y_r     [4];
    logic [DW-1:0] x_new   [6];
    logic [DW-1:0] p_new   [36];

    logic signed [AW-1:0] acc;
    logic [1:0] mac;
    logic [2:0] row;
    logic [2:0] col;
    logic       last_mac;

    logic [2:0] sel;
    logic [4:0] k_idx;
    logic [5:0] ph_idx;
    logic [5:0] p_idx;
    logic signed [DW-1:0] op_a;
    logic signed [DW-1:0] op_b;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_base;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] term;
    logic signed [RW-1:0] y_wide;
    logic signed [RW-1:0] x_wide;
    logic signed [RW-1:0] p_wide;
    logic [DW-1:0] y_red;
    logic [DW-1:0] x_red;
    logic [DW-1:0] p_red;
    logic [6*DW-1:0]  x_pack;
    logic [36*DW-1:0] p_pack;

    // Reduce a wide signed value to DW bits: wrap, or clamp when SAT is set.
    function automatic logic [DW-1:0] reduce(input logic [RW-1:0] v);
        logic hi;
        logic lo;
        hi = !v[RW-1] && (|v[RW-2:DW-1]);
        lo =  v[RW-1] && !(&v[RW-2:DW-1]);
        if (SAT && hi)
            return {1'b0, {(DW-1){1'b1}}};
        else if (SAT && lo)
            return {1'b1, {(DW-1){1'b0}}};
        else
            return v[DW-1:0];
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        last_mac   = (mac == 2'd3);
        case (state)
            ST_IDLE:  if (io.start) state_next = ST_INNOV;
            ST_INNOV: if (last_mac) state_next = ST_XUPD;
            ST_XUPD:  if (last_mac && row == 3'd5) state_next = ST_PUPD;
            ST_PUPD:  if (last_mac && row == 3'd5 && col == 3'd5) state_next = ST_DONE;
            ST_DONE:  if (!io.start) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Shared MAC datapath: operand muxing, accumulation, rescale and reduction.
    always_comb begin
        sel      = {mac[1], 1'b0, mac[0]};
        k_idx    = {row, 2'b00} + {3'b000, mac};
        ph_idx   = ({3'b000, sel} * 6'd6) + {3'b000, col};
        p_idx    = ({3'b000, row} * 6'd6) + {3'b000, col};
        op_a     = k_r[k_idx];
        op_b     = (state == ST_PUPD) ? ph_r[ph_idx] : y_r[mac];
        prod     = $signed({{DW{op_a[DW-1]}}, op_a}) * $signed({{DW{op_b[DW-1]}}, op_b});
        acc_base = (mac == 2'd0) ? '0 : acc;
        acc_sum  = acc_base + $signed({{2{prod[PW-1]}}, prod});
        term     = acc_sum >>> FRAC;
        y_wide   = $signed({{(RW-DW){z_r[mac][DW-1]}}, z_r[mac]})
                 - $signed({{(RW-DW){x_hat_r[sel][DW-1]}}, x_hat_r[sel]});
        x_wide   = $signed({{(RW-DW){x_hat_r[row][DW-1]}}, x_hat_r[row]})
                 + $signed({term[AW-1], term});
        p_wide   = $signed({{(RW-DW){ph_r[p_idx][DW-1]}}, ph_r[p_idx]})
                 - $signed({term[AW-1], term});
        y_red    = reduce(y_wide);
        x_red    = reduce(x_wide);
        p_red    = reduce(p_wide);
        x_pack   = '0;
        for (int unsigned e = 0; e < 6; e++)
            x_pack[(5-e)*DW +: DW] = x_new[e];
        p_pack   = '0;
        for (int unsigned e = 0; e < 36; e++)
            p_pack[(35-e)*DW +: DW] = p_new[e];
        // Element (5,5) finishes on the completing edge itself, so it is
        // taken straight from the datapath rather than from p_new.
        p_pack[DW-1:0] = p_red;
    end

    // Operand latches, sequencing counters, result registers and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned e = 0; e < 6; e++)  x_hat_r[e] <= '0;
            for (int unsigned e = 0; e < 4; e++)  z_r[e]     <= '0;
            for (int unsigned e = 0; e < 24; e++) k_r[e]     <= '0;
            for (int unsigned e = 0; e < 36; e++) ph_r[e]    <= '0;
            for (int unsigned e = 0; e < 4; e++)  y_r[e]     <= '0;
            for (int unsigned e = 0; e < 6; e++)  x_new[e]   <= '0;
            for (int unsigned e = 0; e < 36; e++) p_new[e]   <= '0;
            acc        <= '0;
            mac        <= '0;
            row        <= '0;
            col        <= '0;
            io.x_flat  <= '0;
            io.P_flat  <= '0;
            io.busy    <= 1'b0;
            io.done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io.start) begin
                        for (int unsigned e = 0; e < 6; e++)
                            x_hat_r[e] <= io.x_hat_flat[(5-e)*DW +: DW];
                        for (int unsigned e = 0; e < 4; e++)
                            z_r[e] <= io.z_flat[(3-e)*DW +: DW];
                        for (int unsigned e = 0; e < 24; e++)
                            k_r[e] <= io.K_flat[(23-e)*DW +: DW];
                        for (int unsigned e = 0; e < 36; e++)
                            ph_r[e] <= io.Phat_flat[(35-e)*DW +: DW];
                        mac     <= '0;
                        row     <= '0;
                        col     <= '0;
                        io.busy <= 1'b1;
                    end
                end
                ST_INNOV: begin
                    y_r[mac] <= y_red;
                    mac      <= mac + 2'd1;
                end
                ST_XUPD: begin
                    mac <= mac + 2'd1;
                    if (last_mac) begin
                        x_new[row] <= x_red;
                        row        <= (row == 3'd5) ? 3'd0 : row + 3'd1;
                    end else begin
                        acc <= acc_sum;
                    end
                end
                ST_PUPD: begin
                    mac <= mac + 2'd1;
                    if (last_mac) begin
                        p_new[p_idx] <= p_red;
                        if (col == 3'd5) begin
                            col <= '0;
                            if (row == 3'd5) begin
                                row       <= '0;
                                io.x_flat <= x_pack;
                                io.P_flat <= p_pack;
                                io.done   <= 1'b1;
                                io.busy   <= 1'b0;
                            end else begin
                                row <= row + 3'd1;
                            end
                        end else begin
                            col <= col + 3'd1;
                        end
                    end else begin
                        acc <= acc_sum;
                    end
                end
                ST_DONE: begin
                    if (!io.start) io.done <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_kalman_update.sv
// Directed, table-driven bench for kalman_update: vector table applied in a
// loop plus hand-written handshake, ignored-start and mid-run reset sequences.
module tb_kalman_update;
    logic clk;
    logic rst_n;

    kalman_update_if #(.DW(32)) io ();

    kalman_update #(.DW(32), .FRAC(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [191:0]  xh;
        logic [127:0]  z;
        logic [767:0]  k;
        logic [1151:0] ph;
        logic [191:0]  x;
        logic [1151:0] p;
    } vec_t;

    vec_t tab [6];
    int n_pass;
    int n_total;
    logic [191:0] last_x;

    function automatic logic [1151:0] put(input logic [1151:0] v, input int n,
                                          input int e, input logic [31:0] val);
        logic [1151:0] r;
        r = v;
        r[(n-1-e)*32 +: 32] = val;
        return r;
    endfunction

    function automatic logic [1151:0] diag4096();
        logic [1151:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r = put(r, 36, i*7, 32'd4096);
        return r;
    endfunction

    task automatic chk_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic chk_vec(input string name, input logic [1151:0] got,
                           input logic [1151:0] exp, input int n);
        int bad;
        bad = -1;
        n_total++;
        for (int e = n - 1; e >= 0; e--)
            if (got[(n-1-e)*32 +: 32] !== exp[(n-1-e)*32 +: 32]) bad = e;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: element %0d got %08h expected %08h", name, bad,
                      got[(n-1-bad)*32 +: 32], exp[(n-1-bad)*32 +: 32]);
    endtask

    task automatic drive(input int v);
        io.x_hat_flat = tab[v].xh;
        io.z_flat     = tab[v].z;
        io.K_flat     = tab[v].k;
        io.Phat_flat  = tab[v].ph;
    endtask

    // Run vector v; hold keeps start high through completion, pulse_at pulses
    // start on that edge number of the computation (0 = no pulse).
    task automatic apply(input int v, input bit hold, input int pulse_at);
        int  n;
        bit  got;
        @(negedge clk);
        drive(v);
        io.start = 1'b1;
        @(posedge clk);
        #1;
        chk_val($sformatf("v%0d busy_after_accept", v), {63'd0, io.busy}, 64'd1);
        n = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            io.start = hold || (n + 1 == pulse_at);
            if (n == 0) begin
                io.x_hat_flat = '1;
                io.z_flat     = '1;
                io.K_flat     = '1;
                io.Phat_flat  = '1;
            end
            @(posedge clk);
            n++;
            #1;
            if (n == 100)
                chk_vec($sformatf("v%0d x_hold_midrun", v), {960'd0, io.x_flat},
                        {960'd0, last_x}, 6);
            if (io.done) got = 1'b1;
        end
        chk_val($sformatf("v%0d latency", v), 64'(n), 64'd172);
        chk_val($sformatf("v%0d busy_at_done", v), {63'd0, io.busy}, 64'd0);
        chk_vec($sformatf("v%0d x_flat", v), {960'd0, io.x_flat}, {960'd0, tab[v].x}, 6);
        chk_vec($sformatf("v%0d P_flat", v), io.P_flat, tab[v].p, 36);
        last_x = tab[v].x;
        if (hold) begin
            repeat (3) @(posedge clk);
            #1;
            chk_val($sformatf("v%0d done_held", v), {63'd0, io.done}, 64'd1);
        end
        @(negedge clk);
        io.start = 1'b0;
        @(posedge clk);
        #1;
        chk_val($sformatf("v%0d done_drop", v), {63'd0, io.done}, 64'd0);
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        last_x   = '0;
        io.start = 1'b0;
        io.x_hat_flat = '0;
        io.z_flat     = '0;
        io.K_flat     = '0;
        io.Phat_flat  = '0;

        for (int v = 0; v < 6; v++) begin
            tab[v].xh = '0; tab[v].z = '0; tab[v].k = '0;
            tab[v].ph = '0; tab[v].x = '0; tab[v].p = '0;
        end
        // 0: identity pass, K = 0
        for (int i = 0; i < 6; i++) tab[0].xh = 192'(put(1152'(tab[0].xh), 6, i, 32'd4096));
        tab[0].ph = diag4096();
        tab[0].x  = tab[0].xh;
        tab[0].p  = diag4096();
        // 1: half gain on (0,0)
        tab[1].k  = 768'(put(1152'(tab[1].k), 24, 0, 32'd2048));
        tab[1].z  = 128'(put(1152'(tab[1].z), 4, 0, 32'd8192));
        tab[1].ph = diag4096();
        tab[1].x  = 192'(put(1152'(tab[1].x), 6, 0, 32'd4096));
        tab[1].p  = put(diag4096(), 36, 0, 32'd2048);
        // 2: y = -1 with unit gain truncates toward -inf
        tab[2].k  = 768'(put(1152'(tab[2].k), 24, 5, 32'd1));
        tab[2].xh = 192'(put(1152'(tab[2].xh), 6, 1, 32'd5));
        tab[2].z  = 128'(put(1152'(tab[2].z), 4, 1, 32'd4));
        tab[2].x  = 192'(put(1152'(tab[2].x), 6, 1, 32'd4));
        // 3: y = +1 truncates to 0
        tab[3]    = tab[2];
        tab[3].z  = 128'(put(1152'(tab[3].z), 4, 1, 32'd6));
        tab[3].x  = 192'(put(1152'(192'd0), 6, 1, 32'd5));
        // 4: overflow of x[0]
        tab[4].xh = 192'(put(1152'(tab[4].xh), 6, 0, 32'h4000_0000));
        tab[4].z  = 128'(put(1152'(tab[4].z), 4, 0, 32'h7FFF_FFFF));
        tab[4].k  = 768'(put(1152'(tab[4].k), 24, 0, 32'd8192));
`ifdef KALMAN_UPDATE_SAT_EN
        tab[4].x  = 192'(put(1152'(tab[4].x), 6, 0, 32'h7FFF_FFFF));
`else
        tab[4].x  = 192'(put(1152'(tab[4].x), 6, 0, 32'hBFFF_FFFE));
`endif
        // 5: K[2][3] = 1.0 maps measurement 3 (state 5) into row 2
        tab[5].k  = 768'(put(1152'(tab[5].k), 24, 11, 32'd4096));
        tab[5].xh = 192'(put(1152'(tab[5].xh), 6, 5, 32'd10));
        tab[5].z  = 128'(put(1152'(tab[5].z), 4, 3, 32'd30));
        tab[5].ph = put(diag4096(), 36, 32, 32'd100);
        tab[5].x  = 192'(put(1152'(tab[5].xh), 6, 2, 32'd20));
        tab[5].p  = put(put(tab[5].ph, 36, 14, 32'd3996), 36, 17, 32'hFFFF_F000);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_val("reset_done", {63'd0, io.done}, 64'd0);
        chk_val("reset_busy", {63'd0, io.busy}, 64'd0);
        chk_vec("reset_P", io.P_flat, '0, 36);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) apply(v, 1'b0, 0);

        // start held high through completion
        apply(1, 1'b1, 0);
        // start pulse mid-computation is ignored
        apply(2, 1'b0, 50);

        // asynchronous reset during PUPD
        @(negedge clk);
        drive(5);
        io.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        io.start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_val("midreset_done", {63'd0, io.done}, 64'd0);
        chk_val("midreset_busy", {63'd0, io.busy}, 64'd0);
        chk_vec("midreset_x", {960'd0, io.x_flat}, '0, 6);
        chk_vec("midreset_P", io.P_flat, '0, 36);
        @(negedge clk);
        rst_n = 1'b1;
        last_x = '0;
        apply(1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
